pes_bc_ctrl: RTL and testbench

Command-driven sequencer for the 4-bit bidirectional counter. Accepts one command at a time over a valid/ready handshake and drives the counter's enable, direction and clear so that it clears, seeks to a target value, or sweeps up to a target and back to zero. It observes the counter's live value through `cnt_in` and flags completion, abort and watchdog timeout. It sits between a host/test sequencer and the counter datapath.

---
 rtl/pes_bc_ctrl.sv | 147 ++++++++++++++
 tb/tb_pes_bc_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pes_bc_ctrl.sv
// Command sequencer for a 4-bit bidirectional counter: clear, seek, sweep.
// Observes the live count and reports completion, abort and watchdog errors.
module pes_bc_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             ctr_en,
  output logic             ctr_up,
  output logic             ctr_clr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_SEEK = 3'd2;
  localparam logic [2:0] S_UP   = 3'd3;
  localparam logic [2:0] S_DN   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic             err_q, err_d;
  logic             done_q;

  logic at_tgt, at_zero, wd_hit, active;

  assign at_tgt  = (cnt_in == tgt_q);
  assign at_zero = (cnt_in == '0);
  assign wd_hit  = (wd_q == WD_MAX);
  assign active  = (state_q == S_SEEK) ||
                   (state_q == S_UP) ||
                   (state_q == S_DN);

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    wd_d      = wd_q;
    err_d     = err_q;
    cmd_ready = (state_q == S_IDLE) && !abort;
    ctr_en    = 1'b0;
    ctr_up    = 1'b0;
    ctr_clr   = 1'b0;

    if (active && !wd_hit)
      wd_d = wd_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          tgt_d = cmd_target;
          wd_d  = '0;
          err_d = 1'b0;
          unique case (cmd_op)
            2'b00: state_d = S_CLR;
            2'b01: state_d = S_SEEK;
            2'b10: state_d = S_UP;
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_CLR: begin
        ctr_clr = 1'b1;
        state_d = S_DONE;
      end
      S_SEEK: begin
        ctr_up = (tgt_q > cnt_in);
        ctr_en = !at_tgt;
        if (at_tgt) begin
          state_d = S_DONE;
        end else if (wd_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          ctr_en  = 1'b0;
        end
      end
      S_UP: begin
        ctr_up = 1'b1;
        ctr_en = !at_tgt;
        // The turn cycle is not a completion, so the watchdog still applies
        if (wd_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          ctr_en  = 1'b0;
        end else if (at_tgt) begin
          state_d = S_DN;
        end
      end
      S_DN: begin
        ctr_en = !at_zero;
        if (at_zero) begin
          state_d = S_DONE;
        end else if (wd_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          ctr_en  = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (active || state_q == S_CLR)) begin
      state_d = S_IDLE;
      err_d   = err_q;
      ctr_en  = 1'b0;
      ctr_clr = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_pes_bc_ctrl.sv
// Scoreboard bench for pes_bc_ctrl with a behavioural counter in the loop.
// Expected latency, status and step counts come from closed-form rules.
module tb_pes_bc_ctrl;

  localparam int TO = 20;

  logic       Clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_target;
  logic       abort;
  logic [3:0] cnt_in;
  logic       ctr_en, ctr_up, ctr_clr;
  logic       busy, done, err;

  pes_bc_ctrl #(.WIDTH(4), .TIMEOUT(TO)) dut (
    .Clk(Clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_target(cmd_target),
    .abort(abort), .cnt_in(cnt_in),
    .ctr_en(ctr_en), .ctr_up(ctr_up), .ctr_clr(ctr_clr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  // behavioural counter with load and stuck controls
  logic       load_en = 1'b0;
  logic [3:0] load_val = '0;
  logic       stuck = 1'b0;
  logic [3:0] cnt = '0;
  assign cnt_in = cnt;

  always @(posedge Clk) begin
    if (load_en) cnt <= load_val;
    else if (!stuck) begin
      if (ctr_clr) cnt <= '0;
      else if (ctr_en) cnt <= ctr_up ? cnt + 4'd1 : cnt - 4'd1;
    end
  end

  typedef struct {
    int lat; int er; int up; int dn; int clr; int cv;
    bit chk_steps; bit chk_cnt;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t model(int op, int tg, int st, bit stk);
    exp_t e;
    int d, u, c;
    e = '{lat:0, er:0, up:0, dn:0, clr:0, cv:st,
          chk_steps:1, chk_cnt:1};
    case (op)
      0: begin e.lat = 2; e.clr = 1; e.cv = 0; end
      1: begin
        d = (tg > st) ? tg - st : st - tg;
        if (d == 0) e.lat = 2;
        else if (stk || d + 1 > TO) begin
          e.lat = TO + 1; e.er = 1;
          if (tg > st) e.up = TO - 1; else e.dn = TO - 1;
          e.cv = stk ? st : ((tg > st) ? st + TO - 1 : st - (TO - 1));
        end else begin
          e.lat = d + 2; e.cv = tg;
          if (tg > st) e.up = d; else e.dn = d;
        end
      end
      2: begin
        u = (tg - st + 16) % 16;
        c = u + tg + 2;
        if (c <= TO) begin
          e.lat = c + 1; e.up = u; e.dn = tg; e.cv = 0;
        end else begin
          e.lat = TO + 1; e.er = 1;
          e.chk_steps = 0; e.chk_cnt = 0;
        end
      end
      default: begin e.lat = 1; e.er = 1; end
    endcase
    return e;
  endfunction

  // monitor: counts activity since acceptance and checks each done pulse
  int cyc = 0, acc_cyc = 0, n_up = 0, n_dn = 0, n_clr = 0;
  always @(negedge Clk) begin
    exp_t e;
    cyc++;
    if (reset === 1'b1) begin
      if (ctr_en) begin
        if (ctr_up) n_up++; else n_dn++;
      end
      if (ctr_clr) n_clr++;
      if (done) begin
        if (sbq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("done_latency", cyc - acc_cyc, e.lat);
          chk("done_err", err, e.er);
          chk("done_busy", busy, 1);
          if (e.chk_steps) begin
            chk("up_steps", n_up, e.up);
            chk("down_steps", n_dn, e.dn);
            chk("clr_cycles", n_clr, e.clr);
          end
          if (e.chk_cnt) chk("final_cnt", cnt, e.cv);
        end
      end
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc; n_up = 0; n_dn = 0; n_clr = 0;
      end
    end
  end

  task automatic issue(int op, int tg, int st, bit push = 1);
    @(posedge Clk); #1;
    load_en = 1'b1; load_val = 4'(st);
    @(posedge Clk); #1;
    load_en = 1'b0;
    if (push) sbq.push_back(model(op, tg, st, stuck));
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_target = 4'(tg);
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge Clk);
      if (!busy) break;
    end
    chk("idle_wait", busy, 0);
  endtask

  initial begin
    int r;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_target = '0; abort = 1'b0;
    repeat (2) @(posedge Clk);
    #1 reset = 1'b1;
    @(negedge Clk);
    chk("rst_busy", busy, 0);
    chk("rst_en", ctr_en, 0);
    chk("rst_clr", ctr_clr, 0);
    chk("rst_up", ctr_up, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", cmd_ready, 1);

    issue(1, 7, 3);  wait_idle();
    issue(1, 2, 9);  wait_idle();
    issue(1, 5, 5);  wait_idle();
    issue(2, 4, 0);  wait_idle();
    issue(0, 0, 12); wait_idle();
    issue(2, 0, 0);  wait_idle();

    // abort two cycles into a long seek
    issue(1, 15, 0, 0);
    repeat (2) @(posedge Clk);
    #1 abort = 1'b1;
    @(negedge Clk);
    chk("abort_en", ctr_en, 0);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 0);
    @(posedge Clk); #1 abort = 1'b0;
    chk("abort_cnt", cnt, 2);
    @(negedge Clk);
    chk("abort_ready_back", cmd_ready, 1);

    // watchdog with a stuck counter
    stuck = 1'b1;
    issue(1, 10, 0); wait_idle();
    stuck = 1'b0;

    // reserved op, then err clears on next acceptance
    issue(3, 6, 4); wait_idle();
    chk("err_held", err, 1);
    issue(1, 5, 4);
    @(negedge Clk);
    chk("err_cleared", err, 0);
    wait_idle();

    // reset during the down phase of a sweep
    issue(2, 4, 0, 0);
    repeat (6) @(posedge Clk);
    #1 reset = 1'b0;
    @(posedge Clk); #1 reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", ctr_en, 0);
    chk("mid_rst_up", ctr_up, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_ready", cmd_ready, 1);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      issue(r < 2 ? 0 : r < 6 ? 1 : r < 9 ? 2 : 3,
            $urandom_range(0, 15), $urandom_range(0, 15));
      wait_idle();
    end

    repeat (3) @(negedge Clk);
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
